// File: rtl/eprom_pkg.sv
// eprom_pkg: sequencer states, mode encodings and interval sizing helper shared by eprom_prog_seq.
package eprom_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, PULSE, HOLD, READ, CMP, NEXT} state_t;
  localparam logic MODE_PROGRAM = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/eprom_prog_seq_if.sv
// eprom_prog_seq_if: host command, byte stream and status bundle of the EPROM sequencer.
interface eprom_prog_seq_if #(parameter int ADDR_W = 11, parameter int DATA_W = 8);
  logic start;
  logic mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0] len;
  logic [DATA_W-1:0] wr_data;
  logic wr_vld;
  logic wr_rdy;
  logic busy;
  logic done;
  logic err;
  logic [ADDR_W-1:0] err_addr;
  modport master (output start, mode, base_addr, len, wr_data, wr_vld, input wr_rdy, busy, done, err, err_addr);
  modport slave (input start, mode, base_addr, len, wr_data, wr_vld, output wr_rdy, busy, done, err, err_addr);
endinterface

// File: rtl/eprom_prog_seq_delay_timer.sv
// delay_timer: loadable down-counter; expire is high during the last cycle of a loaded interval.
module delay_timer #(parameter int W = 4) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic run,
  input logic [W-1:0] n,
  output logic expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= n;
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expire = cnt == W'(1);
endmodule

// File: rtl/eprom_prog_seq.sv
// eprom_prog_seq: EPROM program/verify sequencer driven by a host byte stream.
// Define PGM_RETRY_EN to read back each programmed byte and re-pulse up to MAX_RETRY times.
module eprom_prog_seq import eprom_pkg::*; #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int PULSE_CYC = 50000,
  parameter int SETUP_CYC = 4,
  parameter int READ_CYC = 4,
  parameter int MAX_RETRY = 3
) (
  input logic clk,
  input logic rst,
  eprom_prog_seq_if.slave host,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_dout,
  output logic rom_oe_n,
  output logic rom_pgm,
  output logic rom_rd_n,
  input logic [DATA_W-1:0] rom_din
);
  localparam int TW = $clog2(max3(PULSE_CYC, SETUP_CYC, READ_CYC)) + 1;
  state_t state, state_nx;
  logic mode_q, abort, expire, load, run, match, accept, take;
  logic [ADDR_W:0] left;
  logic [DATA_W-1:0] rd_q;
  logic [TW-1:0] tn;
  assign accept = state == IDLE && host.start;
  assign take = state == FETCH && host.wr_vld;
  assign match = rd_q == rom_dout;
  assign run = state inside {SETUP, PULSE, HOLD, READ};
  assign load = state_nx != state && state_nx inside {SETUP, PULSE, HOLD, READ};
  assign tn = state_nx == PULSE ? TW'(PULSE_CYC) : state_nx == READ ? TW'(READ_CYC) : TW'(SETUP_CYC);
  delay_timer #(.W(TW)) u_timer (.clk(clk), .rst(rst), .load(load), .run(run), .n(tn), .expire(expire));
`ifdef PGM_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0] tries;
  always_ff @(posedge clk) begin
    if (rst || take) tries <= '0;
    else if (state == CMP && state_nx == SETUP) tries <= tries + 1'b1;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (host.start) state_nx = host.len == '0 ? NEXT : FETCH;
      FETCH: if (host.wr_vld) state_nx = mode_q == MODE_VERIFY ? READ : SETUP;
      SETUP: if (expire) state_nx = PULSE;
      PULSE: if (expire) state_nx = HOLD;
`ifdef PGM_RETRY_EN
      HOLD: if (expire) state_nx = READ;
      CMP: state_nx = (!match && mode_q == MODE_PROGRAM && tries < RW'(MAX_RETRY)) ? SETUP : NEXT;
`else
      HOLD: if (expire) state_nx = NEXT;
      CMP: state_nx = NEXT;
`endif
      READ: if (expire) state_nx = CMP;
      NEXT: state_nx = (left == '0 || abort) ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    host.wr_rdy = state == FETCH;
    host.busy = state != IDLE;
    host.done = state == NEXT && (left == '0 || abort);
    rom_oe_n = !(state inside {SETUP, PULSE, HOLD});
    rom_pgm = state == PULSE;
    rom_rd_n = state != READ;
  end
  // left counts bytes not yet fetched, so NEXT can finish without a separate last-byte flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      rom_dout <= '0;
      left <= '0;
      mode_q <= MODE_PROGRAM;
      abort <= 1'b0;
      rd_q <= '0;
      host.err <= 1'b0;
      host.err_addr <= '0;
    end else begin
      if (accept) begin
        rom_addr <= host.base_addr;
        left <= host.len;
        mode_q <= host.mode;
        abort <= 1'b0;
        host.err <= 1'b0;
        host.err_addr <= '0;
      end
      if (take) begin
        rom_dout <= host.wr_data;
        left <= left - 1'b1;
      end
      if (state == READ && expire) rd_q <= rom_din;
      if (state == CMP && state_nx == NEXT && !match) begin
        abort <= 1'b1;
        host.err <= 1'b1;
        host.err_addr <= rom_addr;
      end
      if (state == NEXT && state_nx == FETCH) rom_addr <= rom_addr + 1'b1;
    end
  end
endmodule

// File: doc/eprom_prog_seq.md
EPROM_PROG_SEQ -- requirements
Module: eprom_prog_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, EPROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, EPROM data width.
REQ-003 SHALL have parameter PULSE_CYC, default 50000, program-pulse width in clk cycles (>=1).
REQ-004 SHALL have parameter SETUP_CYC, default 4, address/data setup and hold in cycles (>=1).
REQ-005 SHALL have parameter READ_CYC, default 4, read strobe width in cycles (>=1).
REQ-006 SHALL have parameter MAX_RETRY, default 3, extra pulses per byte on readback mismatch.
REQ-007 SHALL have ports: clk in 1 system clock; rst in 1 reset.
REQ-008 Clock is clk; reset is rst, synchronous, active-high.
REQ-009 SHALL have ports: start in 1, begin operation; mode in 1, 0=program 1=verify; base_addr in ADDR_W, first address; len in ADDR_W+1, byte count.
REQ-010 SHALL have ports: wr_data in DATA_W, byte to program or expected byte; wr_vld in 1; wr_rdy out 1.
REQ-011 SHALL have ports: busy out 1; done out 1, one-cycle pulse; err out 1; err_addr out ADDR_W.
REQ-012 SHALL have ports: rom_addr out ADDR_W; rom_dout out DATA_W; rom_oe_n out 1, low = block drives data bus; rom_pgm out 1, program pulse; rom_rd_n out 1, read strobe; rom_din in DATA_W.

Function
REQ-013 States: IDLE, FETCH, SETUP, PULSE, HOLD, READ, CMP, NEXT.
REQ-014 start SHALL be sampled only in IDLE; start while busy ignored; base_addr, len, mode latched on acceptance; err and err_addr cleared.
REQ-015 len=0: done SHALL pulse the cycle after acceptance, no rom strobe activity.
REQ-016 FETCH: wr_rdy=1; byte consumed on wr_vld&&wr_rdy; wr_rdy=0 in all other states.
REQ-017 Program: FETCH->SETUP (rom_oe_n=0, rom_addr/rom_dout stable SETUP_CYC cycles)->PULSE (rom_pgm=1 exactly PULSE_CYC cycles)->HOLD (SETUP_CYC cycles, rom_oe_n=0)->NEXT.
REQ-018 Verify: FETCH->READ (rom_oe_n=1, rom_rd_n=0 READ_CYC cycles, rom_din sampled on last)->CMP->NEXT on match.
REQ-019 Verify mismatch SHALL set err=1, err_addr=failing address, end operation with done; no further bytes consumed.
REQ-020 NEXT: rom_addr increments modulo 2^ADDR_W (wrap, no error); after len bytes -> IDLE with done=1 one cycle.
REQ-021 rom_pgm and rom_rd_n=0 SHALL never be active simultaneously; rom_pgm=1 only while rom_oe_n=0.
REQ-022 busy=1 from cycle after acceptance until done cycle inclusive.
REQ-023 err SHALL stay set until next accepted start or rst.

Reset
REQ-024 On rst: state IDLE; rom_pgm=0, rom_rd_n=1, rom_oe_n=1, rom_addr=0, rom_dout=0, wr_rdy=0, busy=0, done=0, err=0, err_addr=0; delay counter cleared.
REQ-025 rst mid-PULSE SHALL drop rom_pgm at that edge; no done pulse emitted.

Configuration
REQ-026 Macro PGM_RETRY_EN defined: program-mode HOLD->READ->CMP; mismatch re-enters SETUP/PULSE up to MAX_RETRY times, then err/err_addr set and operation ends with done.
REQ-027 PGM_RETRY_EN undefined: program mode performs no readback; MAX_RETRY unused; err only from verify mode.

Structure
REQ-028 Shared package eprom_pkg SHALL hold state enum typedef and mode constants MODE_PROGRAM=0, MODE_VERIFY=1.
REQ-029 One sub-module, delay_timer (load count, run, expire flag), SHALL time SETUP, PULSE, HOLD and READ intervals; width $clog2 of largest interval +1.

Verification
REQ-030 Program 3 bytes at base 0x010, PULSE_CYC=10: rom_pgm high exactly 10 cycles per byte at 0x010/011/012, done once, err=0.
REQ-031 Verify len=4 with rom model mismatching at 0x7FE from base 0x7FD: err=1, err_addr=0x7FE, only 2 bytes consumed.
REQ-032 Program base 0x7FF len=2: second byte at rom_addr 0x000, no err.
REQ-033 PGM_RETRY_EN, rom model accepts on third pulse: 3 pulses, err=0; model never accepts, MAX_RETRY=3: 4 pulses, err=1.
REQ-034 rst asserted mid-PULSE, start pulsed while busy, len=0: rom_pgm=0 next cycle, no done; extra start ignored; done one cycle after acceptance.
